accel_csr_master: RTL and testbench

- Bus initiator that programs the matrix-vector accelerator controller's three CSR slave ports (vector size, matrix size, run control).
- Accepts one job command (rows, columns) from the host-side logic, issues the size and run writes with correct strobe timing, and tracks the controller's `ready` to detect busy and completion.
- Clears the run request, then reports done or error.
- Sits between the STM32 host bridge and the accelerator controller.

---
 rtl/accel_csr_pkg.sv | 34 +++
 rtl/bus_if.sv | 11 +
 rtl/accel_csr_master_strobe.sv | 77 +++++++
 rtl/accel_csr_master.sv | 140 ++++++++++++++
 tb/tb_accel_csr_master.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/accel_csr_pkg.sv
// Shared types and constants for the accelerator CSR bus initiator.
package accel_csr_pkg;

  typedef enum logic [3:0] {
    S_INIT_CLR,
    S_IDLE,
    S_CHECK,
    S_WR_VEC,
    S_WR_MAT,
    S_WR_RUN,
    S_WAIT_BUSY,
    S_CLR,
    S_WAIT_DONE,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } phase_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_DIM  = 2'd1;
  localparam logic [1:0] ERR_READY_TO = 2'd2;
  localparam logic [1:0] ERR_DONE_TO  = 2'd3;

  localparam int RUN_BIT = 0;

  localparam logic [1:0] PORT_VEC = 2'd0;
  localparam logic [1:0] PORT_MAT = 2'd1;
  localparam logic [1:0] PORT_CSR = 2'd2;

endpackage

// File: rtl/bus_if.sv
// Simple valid/data/ready CSR write port; the slave latches data on valid's rising edge.
interface bus_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport mst_port (output valid, output data, input ready);
  modport slv_port (input valid, input data, output ready);
endinterface

// File: rtl/accel_csr_master_strobe.sv
// Three-phase SETUP/STROBE/HOLD write sequencer shared by the three CSR ports,
// plus the wait timer (down-counter reloaded whenever the master changes state).
module csr_strobe_gen
  import accel_csr_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       active,
  input  logic                       gate_en,
  input  logic                       restart,
  input  logic [1:0]                 sel,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [2:0]                 ready,
  output logic [2:0]                 valid,
  output logic [2:0][DATA_WIDTH-1:0] data,
  output logic                       wr_done,
  output logic                       setup_to,
  output logic                       tc
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES);

  phase_e                      phase_q, phase_d;
  logic [CW-1:0]               cnt_q;
  logic [2:0][DATA_WIDTH-1:0]  held_q;
  logic                        sel_ready;

  always_comb begin
    sel_ready = 1'b0;
    for (int p = 0; p < 3; p++) if (sel == 2'(p)) sel_ready = ready[p];
  end

  always_comb begin
    phase_d = phase_q;
    if (active) begin
      case (phase_q)
        PH_SETUP:  if (!gate_en || sel_ready) phase_d = PH_STROBE;
        PH_STROBE: phase_d = PH_HOLD;
        default:   phase_d = PH_SETUP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_SETUP;
      cnt_q   <= LOAD;
      held_q  <= '0;
    end else begin
      phase_q <= phase_d;
      if (restart)            cnt_q <= LOAD;
      else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
      if (active && phase_q == PH_STROBE)
        for (int p = 0; p < 3; p++) if (sel == 2'(p)) held_q[p] <= wdata;
    end
  end

  // The selected port shows the live write data; idle ports keep what they last wrote.
  always_comb begin
    valid = '0;
    data  = held_q;
    for (int p = 0; p < 3; p++) begin
      if (active && sel == 2'(p)) begin
        valid[p] = (phase_q == PH_STROBE);
        data[p]  = wdata;
      end
    end
  end

  assign tc       = (cnt_q == '0);
  assign wr_done  = active && (phase_q == PH_HOLD);
  assign setup_to = active && gate_en && (phase_q == PH_SETUP) && !sel_ready && tc;

endmodule

// File: rtl/accel_csr_master.sv
// Programs the matrix-vector controller's size and run CSRs for one job and reports done/err.
//   state       | meaning
//   INIT_CLR    | clear write to run CSR after reset
//   IDLE        | waiting for a job command
//   CHECK       | range-check rows/cols
//   WR_VEC      | write rows to vector-size CSR
//   WR_MAT      | write cols to matrix-size CSR
//   WR_RUN      | write run=1
//   WAIT_BUSY   | wait for controller ready to drop
//   CLR         | clear write to run CSR
//   WAIT_DONE   | wait for controller ready to return
//   DONE        | one-cycle done pulse
module accel_csr_master
  import accel_csr_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_DIM        = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_rows,
  input  logic [7:0]  cmd_cols,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  bus_if.mst_port     vec_csr_if,
  bus_if.mst_port     mat_csr_if,
  bus_if.mst_port     csr_if
);
  state_e                      state_q, state_d;
  logic [1:0]                  err_q, err_d;
  logic [7:0]                  rows_q, cols_q;
  logic [1:0]                  sel;
  logic [DATA_WIDTH-1:0]       wdata;
  logic [2:0]                  valid;
  logic [2:0][DATA_WIDTH-1:0]  data;
  logic                        active, gate_en, wr_done, setup_to, tc, bad_dim;

  assign bad_dim = (rows_q == 8'd0) || (int'(rows_q) > MAX_DIM) ||
                   (cols_q == 8'd0) || (int'(cols_q) > MAX_DIM);
  assign active  = state_q inside {S_INIT_CLR, S_WR_VEC, S_WR_MAT, S_WR_RUN, S_CLR};
  assign gate_en = state_q inside {S_WR_VEC, S_WR_MAT, S_WR_RUN};

  always_comb begin
    sel   = PORT_CSR;
    wdata = '0;
    case (state_q)
      S_WR_VEC: begin sel = PORT_VEC; wdata = DATA_WIDTH'(rows_q); end
      S_WR_MAT: begin sel = PORT_MAT; wdata = DATA_WIDTH'(cols_q); end
      S_WR_RUN: wdata[RUN_BIT] = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_INIT_CLR: if (wr_done) state_d = S_IDLE;
      S_IDLE: if (cmd_valid) begin state_d = S_CHECK; err_d = ERR_NONE; end
      S_CHECK: begin
        if (bad_dim) begin err_d = ERR_BAD_DIM; state_d = S_DONE; end
        else state_d = S_WR_VEC;
      end
      S_WR_VEC, S_WR_MAT, S_WR_RUN: begin
        if (setup_to) begin err_d = ERR_READY_TO; state_d = S_CLR; end
        else if (wr_done) begin
          case (state_q)
            S_WR_VEC: state_d = S_WR_MAT;
            S_WR_MAT: state_d = S_WR_RUN;
            default:  state_d = S_WAIT_BUSY;
          endcase
        end
      end
      S_WAIT_BUSY: begin
        if (!csr_if.ready) state_d = S_CLR;
        else if (tc) begin err_d = ERR_READY_TO; state_d = S_CLR; end
      end
      // An errored job only needed the run latch cleared; skip waiting for completion.
      S_CLR: if (wr_done) state_d = (err_q != ERR_NONE) ? S_DONE : S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (csr_if.ready) state_d = S_DONE;
        else if (tc) begin err_d = ERR_DONE_TO; state_d = S_DONE; end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT_CLR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT_CLR;
      err_q   <= ERR_NONE;
      rows_q  <= '0;
      cols_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && cmd_valid) begin
        rows_q <= cmd_rows;
        cols_q <= cmd_cols;
      end
    end
  end

  csr_strobe_gen #(
    .DATA_WIDTH     (DATA_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (active),
    .gate_en  (gate_en),
    .restart  (state_d != state_q),
    .sel      (sel),
    .wdata    (wdata),
    .ready    ({csr_if.ready, mat_csr_if.ready, vec_csr_if.ready}),
    .valid    (valid),
    .data     (data),
    .wr_done  (wr_done),
    .setup_to (setup_to),
    .tc       (tc)
  );

  assign vec_csr_if.valid = valid[PORT_VEC];
  assign vec_csr_if.data  = data[PORT_VEC];
  assign mat_csr_if.valid = valid[PORT_MAT];
  assign mat_csr_if.data  = data[PORT_MAT];
  assign csr_if.valid     = valid[PORT_CSR];
  assign csr_if.data      = data[PORT_CSR];

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_accel_csr_master.sv
// Randomized job bench for accel_csr_master; expected bus timeline is derived from cycle arithmetic.
module tb_accel_csr_master;
  localparam int T       = 24;
  localparam int MAX_DIM = 64;

  logic       clk, rst_n, cmd_valid, cmd_ready, busy, done;
  logic [7:0] cmd_rows, cmd_cols;
  logic [1:0] err;
  int         n_vec = 0, n_miss = 0;

  bus_if #(.DATA_WIDTH(16)) vec_bus ();
  bus_if #(.DATA_WIDTH(16)) mat_bus ();
  bus_if #(.DATA_WIDTH(16)) csr_bus ();

  accel_csr_master #(
    .DATA_WIDTH     (16),
    .MAX_DIM        (MAX_DIM),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rows   (cmd_rows),
    .cmd_cols   (cmd_cols),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .vec_csr_if (vec_bus),
    .mat_csr_if (mat_bus),
    .csr_if     (csr_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 400) begin @(negedge clk); k++; end
    chk("idle_reached", int'(cmd_ready), 1);
  endtask

  // Cycles 1..4 after reset release: clear write strobe in cycle 2, cmd_ready in cycle 4.
  task automatic check_init(input bit hold);
    int clr_cyc = -1, clr_data = -1, rdy_cyc = -1, stray = 0, k = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (csr_bus.valid && clr_cyc < 0) begin clr_cyc = n; clr_data = int'(csr_bus.data); end
      if (vec_bus.valid || mat_bus.valid) stray++;
      if (cmd_ready && rdy_cyc < 0) rdy_cyc = n;
      @(posedge clk);
    end
    chk("init_clr_cycle", clr_cyc, 2);
    chk("init_clr_data", clr_data, 0);
    chk("init_ready_cycle", rdy_cyc, 4);
    chk("init_stray_valid", stray, 0);
    if (hold) begin
      @(negedge clk);
      chk("hold_ready_low", int'(cmd_ready), 0);
      chk("hold_busy", int'(busy), 1);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("hold_vec_valid", int'(vec_bus.valid), 1);
      chk("hold_vec_data", int'(vec_bus.data), 2);
      while (!done && k < 300) begin @(negedge clk); k++; end
      chk("hold_err", int'(err), 2);
    end
  endtask

  // s: cycles vec ready stays low after WR_VEC begins; d/len: run-to-busy delay and busy length.
  task automatic run_job(input int rows, input int cols, input int s, input int d, input int len);
    int ep[$], ec[$], ed[$];
    int op[$], oc[$], od[$];
    int exp_done, exp_err, obs_done = -1, obs_err = -1, done_cnt = 0, busy_low = 0;
    int run_obs = -1, n = 1, wb, lo, hi, b, wd, w;

    if (rows == 0 || rows > MAX_DIM || cols == 0 || cols > MAX_DIM) begin
      exp_done = 2; exp_err = 1;
    end else if (s > T) begin
      ep.push_back(2); ec.push_back(4 + T); ed.push_back(0);
      exp_done = 6 + T; exp_err = 2;
    end else begin
      ep.push_back(0); ec.push_back(3 + s); ed.push_back(rows);
      ep.push_back(1); ec.push_back(6 + s); ed.push_back(cols);
      ep.push_back(2); ec.push_back(9 + s); ed.push_back(1);
      wb = 11 + s; lo = 9 + s + d; hi = lo + len;
      b  = (lo > wb) ? lo : wb;
      if (b < hi && b <= wb + T) begin
        ep.push_back(2); ec.push_back(b + 2); ed.push_back(0);
        wd = b + 4;
        w  = (hi > wd) ? hi : wd;
        if (w <= wd + T) begin exp_done = w + 1; exp_err = 0; end
        else begin exp_done = wd + T + 1; exp_err = 3; end
      end else begin
        ep.push_back(2); ec.push_back(wb + T + 2); ed.push_back(0);
        exp_done = wb + T + 4; exp_err = 2;
      end
    end

    wait_idle();
    cmd_rows  = 8'(rows);
    cmd_cols  = 8'(cols);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    while (n <= exp_done + 1) begin
      vec_bus.ready = (n >= 2 + s);
      csr_bus.ready = !(run_obs >= 0 && n >= run_obs + d && n < run_obs + d + len);
      @(negedge clk);
      if (vec_bus.valid) begin op.push_back(0); oc.push_back(n); od.push_back(int'(vec_bus.data)); end
      if (mat_bus.valid) begin op.push_back(1); oc.push_back(n); od.push_back(int'(mat_bus.data)); end
      if (csr_bus.valid) begin
        op.push_back(2); oc.push_back(n); od.push_back(int'(csr_bus.data));
        if (csr_bus.data[0] && run_obs < 0) run_obs = n;
      end
      if (done) begin
        done_cnt++;
        if (obs_done < 0) begin obs_done = n; obs_err = int'(err); end
      end
      if (n <= exp_done && !busy) busy_low++;
      if (n == exp_done + 1) begin
        chk("ready_after_done", int'(cmd_ready), 1);
        chk("busy_after_done", int'(busy), 0);
        chk("err_held", int'(err), exp_err);
      end
      @(posedge clk);
      #1 n++;
    end
    vec_bus.ready = 1'b1;
    csr_bus.ready = 1'b1;

    chk("strobe_count", op.size(), ep.size());
    for (int i = 0; i < op.size() && i < ep.size(); i++) begin
      chk("strobe_port", op[i], ep[i]);
      chk("strobe_cycle", oc[i], ec[i]);
      chk("strobe_data", od[i], ed[i]);
    end
    chk("done_cycle", obs_done, exp_done);
    chk("done_err", obs_err, exp_err);
    chk("done_pulses", done_cnt, 1);
    chk("busy_during_job", busy_low, 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rows = '0; cmd_cols = '0;
    vec_bus.ready = 1'b1; mat_bus.ready = 1'b1; csr_bus.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'({vec_bus.valid, mat_bus.valid, csr_bus.valid}), 0);
    chk("rst_vec_data", int'(vec_bus.data), 0);
    chk("rst_mat_data", int'(mat_bus.data), 0);
    chk("rst_csr_data", int'(csr_bus.data), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_init(1'b0);

    run_job(4, 3, 0, 1, 10);
    run_job(0, 5, 0, 1, 10);
    run_job(6, 6, 1000, 1, 5);
    run_job(2, 9, 0, 2, 100000);
    run_job(64, 64, 0, 3, 4);
    run_job(65, 1, 0, 1, 4);
    run_job(1, 64, 0, 5, 2);
    run_job(64, 0, 0, 1, 4);
    run_job(7, 7, 0, T + 10, 5);
    run_job(3, 3, T, 1, 5);

    for (int j = 0; j < 30; j++) begin
      int r, c, s, d, l;
      r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, MAX_DIM));
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, MAX_DIM));
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T + 4)) : 0;
      d = int'($urandom_range(1, T + 6));
      l = int'($urandom_range(1, T + 8));
      run_job(r, c, s, d, l);
    end

    // Reset asserted while waiting for completion, with a command held pending throughout.
    wait_idle();
    cmd_rows = 8'd5; cmd_cols = 8'd7; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int n = 1; n < 18; n++) begin
      csr_bus.ready = (n < 10);
      @(posedge clk);
      #1;
    end
    chk("pre_rst_vec_data", int'(vec_bus.data), 5);
    chk("pre_rst_busy", int'(busy), 1);
    cmd_rows = 8'd2; cmd_cols = 8'd2; cmd_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'({vec_bus.valid, mat_bus.valid, csr_bus.valid}), 0);
    chk("mid_rst_vec_data", int'(vec_bus.data), 0);
    chk("mid_rst_mat_data", int'(mat_bus.data), 0);
    chk("mid_rst_csr_data", int'(csr_bus.data), 0);
    csr_bus.ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_init(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
